// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V core constants, fetch FSM states and the fetch queue entry type.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FULL
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetched {pc, inst} pairs with synchronous flush.
//   clk, rst_n       : clock, asynchronous active-low reset
//   push, push_data  : write an entry (a push when full is accepted only alongside a pop)
//   pop, pop_data    : remove the head entry; pop_data always shows the head
//   flush            : empty the queue; overrides push and pop
//   full, empty, count : occupancy status
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           do_push, do_pop;

    assign full     = cnt_q == (AW+1)'(DEPTH);
    assign empty    = cnt_q == '0;
    assign count    = cnt_q;
    assign pop_data = mem_q[rd_q];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_comb begin
        wr_d  = flush ? '0 : wr_q + AW'(do_push);
        rd_d  = flush ? '0 : rd_q + AW'(do_pop);
        cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: only entries below the count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem_q[wr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetch with redirect and in-order response queue.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   redirect_valid, redirect_pc    : restart fetching at redirect_pc (word aligned)
//   mem_req_valid/addr/ready       : instruction memory read request handshake
//   mem_rsp_valid, mem_rsp_data    : in-order read responses
//   inst_valid, inst, inst_pc      : head of the instruction queue to the core
//   inst_ready                     : core consumes the head this cycle
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outst_q, outst_d, drop_q, drop_d, fifo_count;
    logic [CW:0]     used_d;
    logic            hs, rsp_acc, push, pop, fifo_full, fifo_empty;
    fetch_entry_t    head;

    assign mem_req_valid = state_q == ST_RUN;
    assign mem_req_addr  = fetch_pc_q;
    assign hs            = mem_req_valid && mem_req_ready;
    // A response only counts against an outstanding request; strays are ignored.
    assign rsp_acc       = mem_rsp_valid && outst_q != '0;
    assign pop           = inst_valid && inst_ready && !redirect_valid;
    assign push          = rsp_acc && drop_q == '0 && !redirect_valid && (!fifo_full || pop);
    assign inst_valid    = !fifo_empty;
    assign inst          = inst_valid ? head.inst : '0;
    assign inst_pc       = inst_valid ? head.pc : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q + CW'(hs) - CW'(rsp_acc);
        drop_d     = drop_q - CW'(rsp_acc && drop_q != '0);
        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old stream.
            fetch_pc_d = redirect_pc & ~32'h3;
            rsp_pc_d   = redirect_pc & ~32'h3;
            drop_d     = outst_d;
        end else begin
            fetch_pc_d = hs ? fetch_pc_q + 32'd4 : fetch_pc_q;
            rsp_pc_d   = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
        end
        // Queue slots plus in-flight requests next cycle; credits are DEPTH minus this.
        used_d  = (CW+1)'(outst_d) + (redirect_valid ? '0 :
                  (CW+1)'(fifo_count) + (CW+1)'(push) - (CW+1)'(pop));
        state_d = state_q == ST_BOOT ? ST_RUN :
                  used_d == (CW+1)'(DEPTH) ? ST_FULL : ST_RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ('{pc: rsp_pc_q, inst: mem_rsp_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        r2_valid, i2_valid;
    logic [31:0] r2_addr, i2_inst, i2_pc;

    logic        rsp_en = 1'b0;
    logic [31:0] pend[$];
    int          hs_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    bit          found;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .mem_req_valid(r2_valid), .mem_req_addr(r2_addr), .mem_req_ready(1'b1),
        .mem_rsp_valid(1'b0), .mem_rsp_data(32'h0),
        .inst_valid(i2_valid), .inst(i2_inst), .inst_pc(i2_pc), .inst_ready(1'b0)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return ~a + 32'h0000_1013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: record a handshake seen before the edge, then drive the
    // memory response for the new cycle from the in-order pending list.
    task automatic step();
        if (mem_req_valid && mem_req_ready) begin
            pend.push_back(mem_req_addr);
            hs_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        if (rsp_en && pend.size() > 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = word(pend.pop_front());
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        mem_req_ready = 1'b0;
        rsp_en = 1'b0;
        inst_ready = 1'b0;
        step();
        step();
        pend.delete();
        mem_rsp_valid = 1'b0;
        check("rst_req_valid", 32'(mem_req_valid), 32'h0);
        check("rst_inst_valid", 32'(inst_valid), 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_req_addr", mem_req_addr, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic wait_inst(input string tag);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (inst_valid) found = 1'b1;
            else step();
        end
        check(tag, 32'(found), 32'h1);
    endtask

    initial begin
        @(negedge clk);
        // Streaming fetch after reset, plus wrap-around on the second instance.
        do_reset();
        mem_req_ready = 1'b1; rsp_en = 1'b1; inst_ready = 1'b1;
        check("boot_no_req", 32'(mem_req_valid), 32'h0);
        step();
        check("s1_valid", 32'(mem_req_valid), 32'h1);
        check("s1_addr", mem_req_addr, 32'h0);
        check("s1_inst_valid", 32'(inst_valid), 32'h0);
        check("w1_addr", r2_addr, 32'hFFFF_FFF8);
        step();
        check("s2_addr", mem_req_addr, 32'h4);
        check("s2_inst_valid", 32'(inst_valid), 32'h0);
        check("w2_addr", r2_addr, 32'hFFFF_FFFC);
        step();
        check("s3_inst_valid", 32'(inst_valid), 32'h1);
        check("s3_inst_pc", inst_pc, 32'h0);
        check("s3_inst", inst, word(32'h0));
        check("s3_addr", mem_req_addr, 32'h8);
        check("w3_addr", r2_addr, 32'h0);
        step();
        check("s4_inst_pc", inst_pc, 32'h4);
        check("w4_addr", r2_addr, 32'h4);
        check("w4_valid", 32'(r2_valid), 32'h1);
        step();
        check("s5_inst_pc", inst_pc, 32'h8);
        check("s5_inst", inst, word(32'h8));
        check("w5_full", 32'(r2_valid), 32'h0);
        check("w5_inst_valid", 32'(i2_valid), 32'h0);
        check("w5_inst", i2_inst ^ i2_pc, 32'h0);

        // Back-pressure: credits cap outstanding plus queued work at DEPTH.
        do_reset();
        mem_req_ready = 1'b1; rsp_en = 1'b1; inst_ready = 1'b0;
        hs_cnt = 0;
        repeat (12) step();
        check("bp_hs_count", 32'(hs_cnt), 32'd4);
        check("bp_req_low", 32'(mem_req_valid), 32'h0);
        check("bp_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        hs_cnt = 0;
        repeat (8) step();
        check("bp_one_more", 32'(hs_cnt), 32'd1);
        check("bp_req_low2", 32'(mem_req_valid), 32'h0);
        check("bp_head_pc2", inst_pc, 32'h4);

        // Redirect with two requests outstanding, unaligned target.
        do_reset();
        mem_req_ready = 1'b1; rsp_en = 1'b0; inst_ready = 1'b1;
        step();
        step();
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; mem_req_ready = 1'b0; rsp_en = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("rd_valid", 32'(mem_req_valid), 32'h1);
        check("rd_addr", mem_req_addr, 32'h100);
        check("rd_inst_valid0", 32'(inst_valid), 32'h0);
        mem_req_ready = 1'b1;
        step();
        check("rd_inst_valid1", 32'(inst_valid), 32'h0);
        check("rd_addr_next", mem_req_addr, 32'h104);
        step();
        check("rd_inst_valid2", 32'(inst_valid), 32'h0);
        step();
        check("rd_first_valid", 32'(inst_valid), 32'h1);
        check("rd_first_pc", inst_pc, 32'h100);
        check("rd_first_inst", inst, word(32'h100));

        // Redirect coinciding with a response, a pop and a handshake.
        do_reset();
        mem_req_ready = 1'b1; rsp_en = 1'b1; inst_ready = 1'b1;
        step();
        step();
        step();
        check("co_pre_valid", 32'(inst_valid), 32'h1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        check("co_flushed", 32'(inst_valid), 32'h0);
        check("co_addr", mem_req_addr, 32'h200);
        step();
        check("co_dropped", 32'(inst_valid), 32'h0);
        step();
        check("co_new_valid", 32'(inst_valid), 32'h1);
        check("co_new_pc", inst_pc, 32'h200);
        // Back-to-back redirects: the second target wins.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        step();
        redirect_pc = 32'h0000_0404;
        step();
        redirect_valid = 1'b0;
        check("bb_addr", mem_req_addr, 32'h404);
        check("bb_inst_valid", 32'(inst_valid), 32'h0);
        wait_inst("bb_timeout");
        check("bb_pc", inst_pc, 32'h404);
        check("bb_inst", inst, word(32'h404));

        // Reset pulse with three requests in flight; their late responses are ignored.
        do_reset();
        mem_req_ready = 1'b1; rsp_en = 1'b0; inst_ready = 1'b1;
        repeat (4) step();
        check("rp_pending", 32'(pend.size()), 32'd3);
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        step();
        check("rp_in_reset_req", 32'(mem_req_valid), 32'h0);
        check("rp_in_reset_inst", 32'(inst_valid), 32'h0);
        rst_n = 1'b1; rsp_en = 1'b1;
        step();
        check("rp_restart_valid", 32'(mem_req_valid), 32'h1);
        check("rp_restart_addr", mem_req_addr, 32'h0);
        step();
        check("rp_ign1", 32'(inst_valid), 32'h0);
        step();
        check("rp_ign2", 32'(inst_valid), 32'h0);
        step();
        check("rp_ign3", 32'(inst_valid), 32'h0);
        check("rp_addr_stable", mem_req_addr, 32'h0);
        mem_req_ready = 1'b1;
        wait_inst("rp_timeout");
        check("rp_pc", inst_pc, 32'h0);
        check("rp_inst", inst, word(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL expose parameter DEPTH, default 4, meaning instruction queue entries and maximum outstanding memory requests (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port redirect_valid, input, 1, meaning the core requests a fetch restart (taken branch or jump, PCsel).
REQ-006 The block SHALL have port redirect_pc, input, 32, the restart target (ALU result).
REQ-007 The block SHALL have port mem_req_valid, output, 1, meaning an instruction memory read request is presented.
REQ-008 The block SHALL have port mem_req_addr, output, 32, the word address of that request.
REQ-009 The block SHALL have port mem_req_ready, input, 1, meaning memory accepts the request this cycle.
REQ-010 The block SHALL have port mem_rsp_valid, input, 1, meaning read data returns this cycle, in request order.
REQ-011 The block SHALL have port mem_rsp_data, input, 32, the returned instruction word.
REQ-012 The block SHALL have port inst_valid, output, 1, meaning inst/inst_pc hold a valid instruction for the core.
REQ-013 The block SHALL have port inst, output, 32, the instruction word.
REQ-014 The block SHALL have port inst_pc, output, 32, the address of inst.
REQ-015 The block SHALL have port inst_ready, input, 1, meaning the core consumes inst this cycle.

Function
REQ-016 States SHALL be BOOT (first cycle after reset release, no request), RUN (issuing), and FULL (credits exhausted, mem_req_valid low); BOOT->RUN unconditionally, RUN->FULL when credits reach 0, FULL->RUN when a credit frees.
REQ-017 Credits SHALL equal DEPTH minus (queued entries plus outstanding requests); mem_req_valid SHALL be high in RUN only, with mem_req_addr = fetch_pc.
REQ-018 On request handshake (mem_req_valid and mem_req_ready), fetch_pc SHALL advance by 4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-019 mem_req_valid and mem_req_addr SHALL stay stable until handshake unless a redirect occurs.
REQ-020 Each non-dropped response SHALL be written into the queue with its issue address; inst_valid SHALL rise the cycle after mem_rsp_valid (one-cycle latency, no bypass).
REQ-021 The queue SHALL be FIFO; the head pops on inst_valid and inst_ready; a simultaneous push and pop at full or empty SHALL be legal and lose nothing.
REQ-022 On redirect_valid, next cycle: queue empty, inst_valid low, fetch_pc = {redirect_pc[31:2],2'b00}, drop counter = outstanding count including any request handshaken in the redirect cycle.
REQ-023 While the drop counter is non-zero, each response SHALL decrement it and SHALL NOT enter the queue; a response in the redirect cycle itself SHALL be dropped.
REQ-024 Redirect SHALL take priority over push, pop and pc increment in the same cycle; back-to-back redirects SHALL each apply, the last one winning.
REQ-025 Requests to the redirect target SHALL be issued from the cycle after redirect, subject to credits (drops still count as outstanding).
REQ-026 Responses with no outstanding request SHALL be ignored.

Reset
REQ-027 While rst_n is low: fetch_pc = RESET_PC, queue empty, outstanding and drop counters 0, state BOOT, mem_req_valid 0, inst_valid 0, inst 0, inst_pc 0.
REQ-028 Reset asserted mid-operation SHALL discard all queued and outstanding work; responses arriving after release SHALL be ignored per REQ-026.

Structure
REQ-029 A shared package riscv_pkg SHALL hold XLEN = 32, RESET_PC default, INST_NOP = 32'h0000_0013 and the fetch state enumeration.
REQ-030 The queue SHALL be a sub-module fetch_fifo (DEPTH entries of {pc, inst}, push/pop/flush, full/empty/count).

Verification
REQ-031 Reset release, memory always ready with 1-cycle response: requests 0x0,0x4,0x8...; inst_valid first high 3 cycles after release with inst_pc 0x0.
REQ-032 inst_ready held low, DEPTH=4: exactly 4 requests issued, then mem_req_valid low; one pop re-enables exactly one request.
REQ-033 Redirect to 0x0000_0103 with 2 requests outstanding: next request addr 0x0000_0100, both stale responses dropped, first inst_pc delivered 0x0000_0100.
REQ-034 Redirect, response and pop in same cycle: queue empty next cycle, response dropped, no inst_valid for old stream.
REQ-035 RESET_PC = 0xFFFF_FFF8: requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-036 rst_n pulsed low with 3 outstanding, then those responses arrive: all ignored, fetch restarts at RESET_PC.
